intf_byte_link: RTL and testbench

//   Byte-wide shared-signal carrier: one registered signed byte "x" that several

---
 rtl/intf_byte_link.sv | 63 ++++++
 tb/tb_intf_byte_link.sv | 136 +++++++++++++
 2 files changed

// File: rtl/intf_byte_link.sv
// Shared signed-byte carrier: priority-arbitrated multi-writer register with a
// sticky valid flag, a conflict pulse and width-derived constant taps.
module intf_byte_link #(
  parameter int DATA_W     = 8,
  parameter int NUM_WR     = 2,
  parameter int NUM_TAPS   = 2,
  parameter int TAP_OFFSET = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]        x,
  output logic                     x_valid,
  output logic                     conflict,
  output logic [7:0]               width_o,
  output logic [NUM_TAPS*8-1:0]    taps
);

  logic [DATA_W-1:0] sel_data;
  logic              any_wr;
  logic              multi_wr;
  logic              found;

  // Lowest-index asserted writer wins.
  always_comb begin
    sel_data = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      if (wr_en[i] && !found) begin
        sel_data = wr_data[i*DATA_W +: DATA_W];
        found    = 1'b1;
      end
    end
  end

  assign any_wr   = |wr_en;
  // Clearing the lowest set bit leaves something only if two or more are set.
  assign multi_wr = |(wr_en & (wr_en - NUM_WR'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x        <= '0;
      x_valid  <= 1'b0;
      conflict <= 1'b0;
    end else begin
      if (any_wr) begin
        x       <= sel_data;
        x_valid <= 1'b1;
      end
      conflict <= multi_wr;
    end
  end

  localparam int WIDTH_VAL = DATA_W;
  assign width_o = WIDTH_VAL[7:0];

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    localparam int TAP_VAL = DATA_W - TAP_OFFSET + k;
    assign taps[k*8 +: 8] = TAP_VAL[7:0];
  end

endmodule

// File: tb/tb_intf_byte_link.sv
// Directed self-checking bench for intf_byte_link with default parameters.
module tb_intf_byte_link;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wr_en;
  logic [15:0] wr_data;
  logic [7:0]  x;
  logic        x_valid;
  logic        conflict;
  logic [7:0]  width_o;
  logic [15:0] taps;

  int n_checks = 0;
  int n_errors = 0;

  intf_byte_link #(
    .DATA_W    (8),
    .NUM_WR    (2),
    .NUM_TAPS  (2),
    .TAP_OFFSET(5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .x       (x),
    .x_valid (x_valid),
    .conflict(conflict),
    .width_o (width_o),
    .taps    (taps)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive at negedge, sample 1 ns after the following rising edge.
  task automatic cycle(input logic [1:0] en, input logic [7:0] d0, input logic [7:0] d1);
    @(negedge clk);
    wr_en   = en;
    wr_data = {d1, d0};
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 2'b11;
    wr_data = 16'hA5A5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_x_wr_ignored", 32'(x), 32'h00);
    check("rst_valid", 32'(x_valid), 32'h0);
    check("rst_conflict", 32'(conflict), 32'h0);
    check("width_o", 32'(width_o), 32'd8);
    check("tap0", 32'(taps[7:0]), 32'd3);
    check("tap1", 32'(taps[15:8]), 32'd4);

    @(negedge clk);
    wr_en = 2'b00;
    rst_n = 1'b1;
    cycle(2'b00, 8'h00, 8'h00);
    check("post_rst_x", 32'(x), 32'h00);
    check("post_rst_valid", 32'(x_valid), 32'h0);

    cycle(2'b01, 8'h01, 8'h77);
    check("w0_x", 32'(x), 32'h01);
    check("w0_valid", 32'(x_valid), 32'h1);
    check("w0_conflict", 32'(conflict), 32'h0);
    cycle(2'b00, 8'hEE, 8'hEE);
    check("w0_hold_x", 32'(x), 32'h01);
    check("w0_hold_valid", 32'(x_valid), 32'h1);

    cycle(2'b10, 8'h33, 8'h02);
    check("w1_x", 32'(x), 32'h02);
    check("w1_conflict", 32'(conflict), 32'h0);

    cycle(2'b11, 8'h01, 8'h02);
    check("both_x_low_wins", 32'(x), 32'h01);
    check("both_conflict", 32'(conflict), 32'h1);
    cycle(2'b00, 8'h00, 8'h00);
    check("conflict_pulse_end", 32'(conflict), 32'h0);
    check("after_conflict_x", 32'(x), 32'h01);

    cycle(2'b11, 8'h80, 8'h7F);
    check("both2_x", 32'(x), 32'h80);
    check("both2_conflict", 32'(conflict), 32'h1);
    cycle(2'b01, 8'h80, 8'h00);
    check("same_val_x", 32'(x), 32'h80);
    check("same_val_conflict", 32'(conflict), 32'h0);

    cycle(2'b10, 8'h00, 8'hFF);
    check("ff_signed", 32'($signed(x)), 32'hFFFF_FFFF);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_x", 32'(x), 32'h00);
    check("async_rst_valid", 32'(x_valid), 32'h0);
    check("async_rst_conflict", 32'(conflict), 32'h0);
    @(negedge clk);
    wr_en   = 2'b01;
    wr_data = 16'h0042;
    @(posedge clk);
    #1;
    check("write_in_rst_lost", 32'(x), 32'h00);
    check("valid_in_rst", 32'(x_valid), 32'h0);
    @(negedge clk);
    wr_en = 2'b00;
    rst_n = 1'b1;
    cycle(2'b00, 8'h00, 8'h00);
    check("valid_after_rst", 32'(x_valid), 32'h0);

    cycle(2'b01, 8'h5A, 8'h00);
    check("5a_x", 32'(x), 32'h5A);
    check("5a_valid", 32'(x_valid), 32'h1);
    for (int i = 0; i < 10; i++) begin
      cycle(2'b00, 8'(i), 8'(~i));
      check("idle_x", 32'(x), 32'h5A);
      check("idle_conflict", 32'(conflict), 32'h0);
    end
    check("idle_valid", 32'(x_valid), 32'h1);
    check("width_o_end", 32'(width_o), 32'd8);
    check("taps_end", 32'(taps), 32'h0403);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
